// File: rtl/display_scan_controller.sv
// Scan sequencer and 16-bit serializer for a multiplexed 7-segment display.
// Each digit: select, capture {dp,segments,digit-enables}, shift out MSB first, latch, dwell.
module display_scan_controller #(
  parameter int NUM_DIGITS  = 6,
  parameter int DIV         = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       dp_in,
  input  logic [6:0] led_in,
  output logic [2:0] segment_select,
  output logic       serial_data,
  output logic       serial_clk,
  output logic       latch,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHIFT   = 3'd3,
    S_LATCH   = 3'd4,
    S_HOLD    = 3'd5
  } state_e;

  // One counter serves bit timing, latch width and dwell, so size it for the largest.
  localparam int CNT_MAX = (2 * DIV > HOLD_CYCLES) ? 2 * DIV : HOLD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] HALF_C     = CW'(DIV);
  localparam logic [CW-1:0] BIT_END    = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] LATCH_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

  state_e        state_q, state_d;
  logic [2:0]    digit_q, digit_d;
  logic [15:0]   shift_q, shift_d;
  logic [4:0]    bits_q, bits_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      digit_q <= 3'd0;
      shift_q <= 16'd0;
      bits_q  <= 5'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_SELECT;
      end
      S_SELECT: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        shift_d = {dp_in, led_in, ~(8'b1 << digit_q)};
        bits_d  = 5'd16;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // End of the high phase: advance to the next bit.
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {shift_q[14:0], 1'b0};
          bits_d  = bits_q - 5'd1;
          if (bits_q == 5'd1) state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_END) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_END) begin
          cnt_d = '0;
          if (digit_q == LAST_DIGIT) begin
            digit_d    = 3'd0;
            frame_done = 1'b1;
          end else begin
            digit_d = digit_q + 3'd1;
          end
          state_d = en ? S_SELECT : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode directly from registers so reset clears them without a clock.
  assign segment_select = digit_q;
  assign busy           = (state_q != S_IDLE);
  assign serial_data    = (state_q == S_SHIFT) && shift_q[15];
  assign serial_clk     = (state_q == S_SHIFT) && (cnt_q >= HALF_C);
  assign latch          = (state_q == S_LATCH);
  assign state_o        = state_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: vector table for a full frame,
// hand-written sequences for late input changes, en drop, async reset and a tiny config.
module tb_display_scan_controller;

  localparam int DIV       = 2;
  localparam int HOLD      = 16;
  localparam int NUM       = 6;
  localparam int DIGIT_LAT = 2 + 32 * DIV + DIV + HOLD;
  localparam int SMALL_LAT = 2 + 32 * 1 + 1 + 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;

  logic       clk = 1'b0;
  logic       reset_n, en, en2, dp_in;
  logic [6:0] led_in;
  logic [2:0] segment_select, state_o;
  logic       serial_data, serial_clk, latch, busy, frame_done;
  logic [2:0] segment_select2, state_o2;
  logic       serial_data2, serial_clk2, latch2, busy2, frame_done2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  display_scan_controller #(.NUM_DIGITS(NUM), .DIV(DIV), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .dp_in(dp_in), .led_in(led_in),
    .segment_select(segment_select), .serial_data(serial_data), .serial_clk(serial_clk),
    .latch(latch), .busy(busy), .frame_done(frame_done), .state_o(state_o)
  );

  display_scan_controller #(.NUM_DIGITS(1), .DIV(1), .HOLD_CYCLES(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en2), .dp_in(dp_in), .led_in(led_in),
    .segment_select(segment_select2), .serial_data(serial_data2), .serial_clk(serial_clk2),
    .latch(latch2), .busy(busy2), .frame_done(frame_done2), .state_o(state_o2)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0]  led;
    logic        dp;
    logic [2:0]  sel;
    logic [15:0] word;
  } vec_t;
  vec_t tbl[6];

  // ---------------- scoreboard / monitors ----------------
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          sel_cyc_q[$];
  logic [2:0]  sel_idx_q[$];
  int          fd_q[$];
  int          lat_w_q[$];
  int          fd2_q[$];
  int          r2_q[$];

  logic [15:0] sh_w;
  logic        prev_sclk, prev_latch, prev_sclk2, sel2_bad;
  logic [2:0]  prev_state;
  int          lat_w;

  always @(negedge clk) begin
    if (!reset_n) begin
      sh_w       <= 16'd0;
      prev_sclk  <= 1'b0;
      prev_latch <= 1'b0;
      prev_state <= ST_IDLE;
      lat_w      <= 0;
    end else begin
      if (serial_clk && !prev_sclk) sh_w <= {sh_w[14:0], serial_data};
      if (latch && !prev_latch) obs_q.push_back(sh_w);
      if (latch) lat_w <= lat_w + 1;
      else if (prev_latch) begin
        lat_w_q.push_back(lat_w);
        lat_w <= 0;
      end
      if (state_o == ST_SELECT && prev_state != ST_SELECT) begin
        sel_cyc_q.push_back(cyc);
        sel_idx_q.push_back(segment_select);
      end
      if (frame_done) fd_q.push_back(cyc);
      prev_sclk  <= serial_clk;
      prev_latch <= latch;
      prev_state <= state_o;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_sclk2 <= 1'b0;
      sel2_bad   <= 1'b0;
    end else begin
      if (frame_done2) fd2_q.push_back(cyc);
      if (serial_clk2 && !prev_sclk2) r2_q.push_back(cyc);
      if (segment_select2 != 3'd0) sel2_bad <= 1'b1;
      prev_sclk2 <= serial_clk2;
    end
  end

  // ---------------- checking / driver tasks ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic auto_drive;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (auto_drive && state_o == ST_SELECT && segment_select < 3'd6) begin
        led_in = tbl[segment_select].led;
        dp_in  = tbl[segment_select].dp;
      end
    end
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int max);
    for (int i = 0; i < max; i++) begin
      if (state_o == st) break;
      step(1);
    end
    check(name, state_o, st);
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      step(1);
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_words(input string name);
    check({name, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(name, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_latch_widths(input string name);
    check({name, "_count"}, (lat_w_q.size() > 0) ? 1 : 0, 1);
    foreach (lat_w_q[i]) check(name, lat_w_q[i], DIV);
    lat_w_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{led: 7'h7E, dp: 1'b1, sel: 3'd0, word: 16'hFEFE};
    tbl[1] = '{led: 7'h30, dp: 1'b0, sel: 3'd1, word: 16'h30FD};
    tbl[2] = '{led: 7'h6D, dp: 1'b1, sel: 3'd2, word: 16'hEDFB};
    tbl[3] = '{led: 7'h79, dp: 1'b0, sel: 3'd3, word: 16'h79F7};
    tbl[4] = '{led: 7'h33, dp: 1'b1, sel: 3'd4, word: 16'hB3EF};
    tbl[5] = '{led: 7'h5B, dp: 1'b0, sel: 3'd5, word: 16'h5BDF};

    reset_n = 1'b0; en = 1'b0; en2 = 1'b0; dp_in = 1'b0; led_in = 7'h00; auto_drive = 1'b0;
    step(3);
    check("rst_serial_clk", serial_clk, 1'b0);
    check("rst_serial_data", serial_data, 1'b0);
    check("rst_latch", latch, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_segment_select", segment_select, 3'd0);
    check("rst_state", state_o, ST_IDLE);
    reset_n = 1'b1;
    step(2);
    check("idle_without_en", busy, 1'b0);

    // Full frame from the table, then into digit 0 of the next frame.
    auto_drive = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 700 && sel_cyc_q.size() < 7; i++) step(1);
    check("frame_select_entries", sel_cyc_q.size(), 7);
    en = 1'b0;
    wait_idle("frame_idle", 200);
    auto_drive = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(tbl[i].word);
    exp_q.push_back(tbl[0].word);
    check_words("frame_word");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("frame_sel_%0d", i), sel_idx_q[i], tbl[i].sel);
      check($sformatf("frame_dwell_%0d", i), sel_cyc_q[i + 1] - sel_cyc_q[i], DIGIT_LAT);
    end
    check("frame_sel_wrap", sel_idx_q[6], 3'd0);
    check("frame_done_count", fd_q.size(), 1);
    check("frame_done_cycle", fd_q[0] - sel_cyc_q[0], NUM * DIGIT_LAT - 1);
    check("frame_idle_sel", segment_select, 3'd1);
    check_latch_widths("frame_latch_width");
    sel_cyc_q.delete(); sel_idx_q.delete(); fd_q.delete();

    // led_in changes two cycles after CAPTURE: word in flight keeps the captured value.
    led_in = 7'h30; dp_in = 1'b0; en = 1'b1;
    wait_state("late_led_capture", ST_CAPTURE, 20);
    step(2);
    led_in = 7'h6D; dp_in = 1'b1; en = 1'b0;
    wait_idle("late_led_idle", 200);
    exp_q.push_back(16'h30FD);
    check_words("late_led_word");
    check("late_led_idle_sel", segment_select, 3'd2);

    // en dropped mid-SHIFT of digit 2: digit completes, then IDLE on digit 3.
    led_in = 7'h79; dp_in = 1'b0; en = 1'b1;
    wait_state("en_drop_shift", ST_SHIFT, 20);
    step(5);
    en = 1'b0;
    wait_idle("en_drop_idle", 200);
    exp_q.push_back(16'h79FB);
    check_words("en_drop_word");
    check("en_drop_idle_sel", segment_select, 3'd3);
    check_latch_widths("en_drop_latch_width");
    en = 1'b1;
    wait_state("reenable_select", ST_SELECT, 5);
    check("reenable_sel", segment_select, 3'd3);

    // Asynchronous reset while serial_clk is high.
    for (int i = 0; i < 100; i++) begin
      if (serial_clk) break;
      step(1);
    end
    check("pre_reset_sclk_high", serial_clk, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_serial_clk", serial_clk, 1'b0);
    check("async_rst_latch", latch, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_sel", segment_select, 3'd0);
    check("async_rst_state", state_o, ST_IDLE);
    step(2);
    reset_n = 1'b1;
    led_in = 7'h33; dp_in = 1'b1;
    wait_state("restart_select", ST_SELECT, 5);
    check("restart_sel", segment_select, 3'd0);
    en = 1'b0;
    wait_idle("restart_idle", 200);
    exp_q.push_back(16'hB3FE);
    check_words("restart_word");
    lat_w_q.delete();

    // Minimal configuration: one digit, DIV=1, one dwell cycle.
    en2 = 1'b1;
    for (int i = 0; i < 200 && fd2_q.size() < 3; i++) step(1);
    en2 = 1'b0;
    check("small_frame_count", (fd2_q.size() >= 3) ? 1 : 0, 1);
    check("small_frame_period_a", fd2_q[1] - fd2_q[0], SMALL_LAT);
    check("small_frame_period_b", fd2_q[2] - fd2_q[1], SMALL_LAT);
    check("small_sclk_period", r2_q[1] - r2_q[0], 2);
    check("small_digit_stays_0", sel2_bad, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
